// File: rtl/seq_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_ram_pkg
// Purpose : Shared sizes and controller state encoding for the sequence RAM.
// Rev     : 1.0  initial release
// ============================================================================
package seq_ram_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;
    localparam int RAM_LEN_W  = RAM_ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_PLAY_ADDR = 3'd2,
        ST_PLAY_SHOW = 3'd3,
        ST_PLAY_GAP  = 3'd4,
        ST_CHK_ADDR  = 3'd5,
        ST_CHK_CMP   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_ram_controller_tick_timer.sv
`default_nettype none
// ============================================================================
// Module  : tick_timer
// Purpose : Loadable down-counter; expire is high while the count sits at zero.
// Rev     : 1.0  initial release
// ============================================================================
module tick_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/seq_ram_controller.sv
`default_nettype none
// ============================================================================
// Module  : seq_ram_controller
// Purpose : Appends, plays back and checks the memory-game sequence RAM.
// Rev     : 1.0  initial release
// ============================================================================
module seq_ram_controller
    import seq_ram_pkg::*;
#(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W,
    parameter int SHOW_CYCLES = 1000,
    parameter int GAP_CYCLES  = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              play_req,
    input  logic              chk_req,
    input  logic [DATA_W-1:0] chk_data,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   length,
    output logic [DATA_W-1:0] led,
    output logic              led_valid,
    output logic              play_done,
    output logic              chk_done,
    output logic              chk_ok,
    output logic              chk_last,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
    localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

    state_t            state_q,     state_d;
    logic [LEN_W-1:0]  length_q,    length_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [DATA_W-1:0] cdata_q,     cdata_d;
    logic [DATA_W-1:0] ram_data_q,  ram_data_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_we_q,    ram_we_d;
    logic              busy_q,      busy_d;
    logic              full_q,      full_d;
    logic              led_valid_q, led_valid_d;
    logic              play_done_q, play_done_d;
    logic              chk_done_q,  chk_done_d;
    logic              chk_ok_q,    chk_ok_d;
    logic              chk_last_q,  chk_last_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expire;
    logic              is_match;
    logic              is_last;
    logic [LEN_W-1:0]  last_pos;

    tick_timer #(
        .WIDTH    (TMR_W)
    ) u_tick_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign last_pos = length_q - LEN_W'(1);
    assign is_match = (ram_q == cdata_q);
    assign is_last  = ({1'b0, ptr_q} == last_pos);

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cdata_d     = cdata_q;
        ram_data_d  = ram_data_q;
        play_done_d = 1'b0;
        chk_done_d  = 1'b0;
        chk_ok_d    = chk_ok_q;
        chk_last_d  = chk_last_q;
        tmr_load    = 1'b0;
        tmr_val     = SHOW_LOAD;

        if (clear) begin
            state_d    = ST_IDLE;
            length_d   = '0;
            ptr_d      = '0;
            chk_ok_d   = 1'b0;
            chk_last_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A write request while full is swallowed, not passed down the priority chain.
                    if (wr_req) begin
                        if (!full_q) begin
                            ram_data_d = wr_data;
                            state_d    = ST_WRITE;
                        end
                    end else if (play_req) begin
                        idx_d = '0;
                        ptr_d = '0;
                        if (length_q == '0) begin
                            play_done_d = 1'b1;
                        end else begin
                            state_d = ST_PLAY_ADDR;
                        end
                    end else if (chk_req) begin
                        cdata_d = chk_data;
                        if (length_q == '0) begin
                            chk_done_d = 1'b1;
                            chk_ok_d   = 1'b0;
                            chk_last_d = 1'b0;
                        end else begin
                            state_d = ST_CHK_ADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    length_d = length_q + LEN_W'(1);
                    state_d  = ST_IDLE;
                end
                ST_PLAY_ADDR: begin
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                    state_d  = ST_PLAY_SHOW;
                end
                ST_PLAY_SHOW: begin
                    if (tmr_expire) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = ST_PLAY_GAP;
                    end
                end
                ST_PLAY_GAP: begin
                    if (tmr_expire) begin
                        if ({1'b0, idx_q} < last_pos) begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = ST_PLAY_ADDR;
                        end else begin
                            play_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                ST_CHK_ADDR: begin
                    state_d = ST_CHK_CMP;
                end
                ST_CHK_CMP: begin
                    chk_done_d = 1'b1;
                    chk_ok_d   = is_match;
                    chk_last_d = is_match & is_last;
                    ptr_d      = (is_match && !is_last) ? ptr_q + ADDR_W'(1) : '0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Port-facing registers follow the state being entered so they line up with it.
        busy_d      = (state_d != ST_IDLE);
        full_d      = (length_d == DEPTH_L);
        ram_we_d    = (state_d == ST_WRITE);
        led_valid_d = (state_d == ST_PLAY_SHOW);
        case (state_d)
            ST_WRITE:                               ram_addr_d = length_q[ADDR_W-1:0];
            ST_PLAY_ADDR, ST_PLAY_SHOW, ST_PLAY_GAP: ram_addr_d = idx_d;
            ST_CHK_ADDR, ST_CHK_CMP:                ram_addr_d = ptr_d;
            default:                                ram_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            length_q    <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            cdata_q     <= '0;
            ram_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            led_valid_q <= 1'b0;
            play_done_q <= 1'b0;
            chk_done_q  <= 1'b0;
            chk_ok_q    <= 1'b0;
            chk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cdata_q     <= cdata_d;
            ram_data_q  <= ram_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
            led_valid_q <= led_valid_d;
            play_done_q <= play_done_d;
            chk_done_q  <= chk_done_d;
            chk_ok_q    <= chk_ok_d;
            chk_last_q  <= chk_last_d;
        end
    end

    // RAM output is already stable for the whole show phase, so only gating is needed.
    assign led       = led_valid_q ? ram_q : '0;
    assign busy      = busy_q;
    assign full      = full_q;
    assign length    = length_q;
    assign led_valid = led_valid_q;
    assign play_done = play_done_q;
    assign chk_done  = chk_done_q;
    assign chk_ok    = chk_ok_q;
    assign chk_last  = chk_last_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;

endmodule
`default_nettype wire
